lbc_arbiter: RTL and testbench
==============================

LBC_ARBITER -- requirements
Module: lbc_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, ACTIVE-state cycles without RDY_n before forced termination; legal range 1..15.
REQ-002 Port: sysclk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: CREQ_n  in  1  CPU request for local memory path, active-low.
REQ-005 Port: BREQ_n  in  1  bus-side (slave) request for local memory path, active-low.
REQ-006 Port: WRITE  in  1  direction of requesting cycle, 1 = write; sampled only on grant.
REQ-007 Port: RDY_n  in  1  local memory ready, active-low.
REQ-008 Port: CGNT_n / BGNT_n  out  1 each  CPU / bus grant, active-low.
REQ-009 Port: CGNT50_n / BGNT50_n  out  1 each  grant delayed one sysclk, active-low.
REQ-010 Port: CACT_n / BACT_n  out  1 each  CPU / bus cycle active, active-low.
REQ-011 Port: TERM_n  out  1  cycle termination strobe, active-low, one cycle wide.
REQ-012 Port: MWRITE_n  out  1  latched memory write strobe direction, active-low.
REQ-013 Port: TOUT  out  1  one-cycle pulse, cycle ended by timeout.

Function
REQ-014 State machine SHALL have states IDLE, GRANT, ACTIVE, TERM; owner register SHALL hold CPU or BUS.
REQ-015 IDLE: one request low -> owner = that requester, go GRANT; both low -> owner = opposite of last_owner (round robin), go GRANT; none -> stay IDLE.
REQ-016 On IDLE->GRANT, WRITE SHALL be latched; MWRITE_n = ~latched WRITE from GRANT through TERM, 1 otherwise.
REQ-017 Owner's xGNT_n SHALL be 0 in GRANT, ACTIVE, TERM; 1 otherwise; non-owner's grant SHALL stay 1.
REQ-018 xGNT50_n SHALL equal owner's xGNT_n delayed one cycle (registered copy), cleared by reset.
REQ-019 GRANT SHALL last exactly one cycle then go ACTIVE, loading timeout counter with TIMEOUT.
REQ-020 Owner's xACT_n SHALL be 0 in ACTIVE and TERM only.
REQ-021 ACTIVE: RDY_n sampled 0 -> TERM; else counter decrements; counter reaching 0 with RDY_n 1 -> TERM with TOUT = 1 in TERM cycle.
REQ-022 RDY_n and counter expiry in the same cycle SHALL count as ready (TOUT stays 0).
REQ-023 TERM: TERM_n = 0 for one cycle, last_owner <= owner, next state IDLE (all grants released).
REQ-024 Request withdrawal during GRANT/ACTIVE SHALL NOT abort the cycle.
REQ-025 Minimum one IDLE cycle SHALL separate consecutive cycles; minimum cycle = request seen in IDLE at edge n, GNT low after n+1, ACT low after n+2, TERM after n+3 (RDY_n already low), IDLE after n+4.
REQ-026 CGNT_n and BGNT_n SHALL never be 0 simultaneously.

Reset
REQ-027 sys_rst_n = 0 SHALL immediately force state IDLE, last_owner BUS, counter 0, all active-low outputs 1, TOUT 0, including mid-cycle.
REQ-028 First arbitration after reset with both requests low SHALL grant CPU.

Structure
REQ-029 Package lbc_arb_pkg SHALL hold state encoding, owner encoding (CPU/BUS), TIMEOUT default and counter width (4).
REQ-030 Sub-module lbc_arb_timer (loadable 4-bit down counter, load/dec/zero flag) SHALL implement the timeout.

Verification
REQ-031 CREQ_n = 0 alone, WRITE = 1, RDY_n = 0 -> CGNT_n low 3 cycles, CACT_n low 2, TERM_n 1 pulse, MWRITE_n = 0, BGNT_n stays 1.
REQ-032 CREQ_n and BREQ_n both held 0 after reset -> grants alternate CPU, BUS, CPU, BUS with one IDLE cycle between.
REQ-033 BREQ_n = 0, RDY_n held 1, TIMEOUT = 15 -> BACT_n low 16 cycles (15 ACTIVE + TERM), TOUT pulse with TERM_n.
REQ-034 RDY_n = 0 coincident with counter = 0 -> TERM_n pulse, TOUT = 0.
REQ-035 sys_rst_n pulsed low during ACTIVE -> all grants/acts/TERM_n go 1 asynchronously, next both-request arbitration grants CPU.
REQ-036 CREQ_n released during ACTIVE -> cycle still completes with TERM_n pulse; BGNT50_n/CGNT50_n lag grants by exactly one cycle throughout.

Source files
------------

// File: rtl/lbc_arb_pkg.sv
// Shared encodings and sizing for the local-bus-controller memory arbiter.
package lbc_arb_pkg;

  localparam int CNT_W       = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TERM   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_BUS = 1'b1
  } owner_e;

endpackage

// File: rtl/lbc_arb_timer.sv
// Loadable down counter; zero_o flags that the count is (or is about to become) zero.
module lbc_arb_timer
  import lbc_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Looks at the next value so a decrement that lands on zero is seen this cycle.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lbc_arbiter.sv
// Two-requester (CPU / bus slave) arbiter for the local memory path with a
// ready timeout. Grants, actives and strobes are decoded from registered state.
module lbc_arbiter
  import lbc_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       CREQ_n,
  input  logic       BREQ_n,
  input  logic       WRITE,
  input  logic       RDY_n,
  output logic       CGNT_n,
  output logic       BGNT_n,
  output logic       CGNT50_n,
  output logic       BGNT50_n,
  output logic       CACT_n,
  output logic       BACT_n,
  output logic       TERM_n,
  output logic       MWRITE_n,
  output logic       TOUT,
  output logic [1:0] dbg_state_o
);

  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  logic   wr_q, wr_d;
  logic   tout_q, tout_d;
  logic   cgnt50_q, bgnt50_q;
  logic   tmr_load, tmr_dec, tmr_zero;
  logic   busy, active, cpu_own;

  lbc_arb_timer u_timer (
    .clk_i      (sysclk),
    .rst_ni     (sys_rst_n),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (TMO_LOAD),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    tout_d   = tout_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tout_d = 1'b0;
        if (!CREQ_n || !BREQ_n) begin
          state_d = ST_GRANT;
          wr_d    = WRITE;
          // Contention goes to whoever did not own the previous cycle.
          if (!CREQ_n && !BREQ_n) begin
            owner_d = (last_q == OWN_CPU) ? OWN_BUS : OWN_CPU;
          end else begin
            owner_d = !CREQ_n ? OWN_CPU : OWN_BUS;
          end
        end
      end
      ST_GRANT: begin
        state_d  = ST_ACTIVE;
        tmr_load = 1'b1;
      end
      ST_ACTIVE: begin
        if (!RDY_n) begin
          state_d = ST_TERM;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_zero) begin
            state_d = ST_TERM;
            tout_d  = 1'b1;
          end
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CPU;
      last_q   <= OWN_BUS;
      wr_q     <= 1'b0;
      tout_q   <= 1'b0;
      cgnt50_q <= 1'b1;
      bgnt50_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      tout_q   <= tout_d;
      cgnt50_q <= CGNT_n;
      bgnt50_q <= BGNT_n;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign active  = (state_q == ST_ACTIVE) || (state_q == ST_TERM);
  assign cpu_own = (owner_q == OWN_CPU);

  assign CGNT_n      = !(busy && cpu_own);
  assign BGNT_n      = !(busy && !cpu_own);
  assign CACT_n      = !(active && cpu_own);
  assign BACT_n      = !(active && !cpu_own);
  assign TERM_n      = (state_q != ST_TERM);
  assign MWRITE_n    = busy ? !wr_q : 1'b1;
  assign TOUT        = (state_q == ST_TERM) && tout_q;
  assign CGNT50_n    = cgnt50_q;
  assign BGNT50_n    = bgnt50_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lbc_arbiter.sv
// Bench for lbc_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_lbc_arbiter;

  localparam int TMO = 15;

  logic       sysclk = 1'b0;
  logic       sys_rst_n;
  logic       CREQ_n, BREQ_n, WRITE, RDY_n;
  logic       CGNT_n, BGNT_n, CGNT50_n, BGNT50_n, CACT_n, BACT_n, TERM_n, MWRITE_n, TOUT;
  logic [1:0] dbg_state;
  logic [8:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  always #5 sysclk = ~sysclk;

  lbc_arbiter #(.TIMEOUT(TMO)) dut (
    .sysclk      (sysclk),
    .sys_rst_n   (sys_rst_n),
    .CREQ_n      (CREQ_n),
    .BREQ_n      (BREQ_n),
    .WRITE       (WRITE),
    .RDY_n       (RDY_n),
    .CGNT_n      (CGNT_n),
    .BGNT_n      (BGNT_n),
    .CGNT50_n    (CGNT50_n),
    .BGNT50_n    (BGNT50_n),
    .CACT_n      (CACT_n),
    .BACT_n      (BACT_n),
    .TERM_n      (TERM_n),
    .MWRITE_n    (MWRITE_n),
    .TOUT        (TOUT),
    .dbg_state_o (dbg_state)
  );

  assign obs = {CGNT_n, BGNT_n, CGNT50_n, BGNT50_n, CACT_n, BACT_n, TERM_n, MWRITE_n, TOUT};

  // Reference model: a transaction is "busy" from grant; age 0 is the grant
  // cycle, ages >= 1 are data-phase cycles, and m_end is the age at which the
  // termination strobe appears once the ending condition has been seen.
  bit m_busy, m_tout, m_wr, m_g50c, m_g50b;
  int m_own, m_last, m_age, m_end;

  function automatic logic [8:0] model_exp();
    logic gc, gb, ac, ab, tm;
    gc = !(m_busy && m_own == 0);
    gb = !(m_busy && m_own == 1);
    ac = !(m_busy && m_age >= 1 && m_own == 0);
    ab = !(m_busy && m_age >= 1 && m_own == 1);
    tm = !(m_busy && m_age == m_end);
    return {gc, gb, m_g50c, m_g50b, ac, ab, tm, (m_busy ? !m_wr : 1'b1), (!tm && m_tout)};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tout = 0; m_wr = 0; m_g50c = 1; m_g50b = 1;
    m_own = 0; m_last = 1; m_age = 0; m_end = -1;
  endtask

  task automatic model_step();
    logic [8:0] e;
    e = model_exp();
    m_g50c = e[8];
    m_g50b = e[7];
    if (!m_busy) begin
      if (!CREQ_n || !BREQ_n) begin
        m_busy = 1;
        m_own  = (!CREQ_n && !BREQ_n) ? (1 - m_last) : (!CREQ_n ? 0 : 1);
        m_wr   = WRITE;
        m_age  = 0;
        m_end  = -1;
        m_tout = 0;
      end
    end else if (m_age == m_end) begin
      m_busy = 0;
      m_last = m_own;
    end else begin
      if (m_age >= 1 && m_end < 0) begin
        if (!RDY_n) m_end = m_age + 1;
        else if (m_age == TMO) begin
          m_end  = m_age + 1;
          m_tout = 1;
        end
      end
      m_age++;
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge sysclk);
    if (sys_rst_n) model_step();
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
  endtask

  task automatic drive(input logic c, input logic b, input logic w, input logic r);
    CREQ_n = c; BREQ_n = b; WRITE = w; RDY_n = r;
  endtask

  // Scoreboard
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic       creq, breq, wr, rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[22];

  initial begin
    int k, guard, bact_lo, tout_at_term, tout_stray, granted;

    // Output order: CGNT BGNT CGNT50 BGNT50 CACT BACT TERM MWRITE TOUT
    vt[0]  = '{0, 0, 0, 0, 9'b011111110};  // contention after reset: CPU
    vt[1]  = '{0, 0, 0, 0, 9'b010101110};
    vt[2]  = '{0, 0, 0, 0, 9'b010101010};
    vt[3]  = '{0, 0, 0, 0, 9'b110111110};  // mandatory idle gap
    vt[4]  = '{0, 0, 0, 0, 9'b101111110};  // round robin: BUS
    vt[5]  = '{0, 0, 0, 0, 9'b101010110};
    vt[6]  = '{0, 0, 0, 0, 9'b101010010};
    vt[7]  = '{0, 0, 0, 0, 9'b111011110};
    vt[8]  = '{0, 0, 0, 0, 9'b011111110};  // back to CPU
    vt[9]  = '{0, 0, 0, 0, 9'b010101110};
    vt[10] = '{0, 0, 0, 0, 9'b010101010};
    vt[11] = '{1, 1, 0, 1, 9'b110111110};
    vt[12] = '{1, 1, 0, 1, 9'b111111110};
    vt[13] = '{0, 1, 1, 0, 9'b011111100};  // CPU write, ready immediately
    vt[14] = '{0, 1, 1, 0, 9'b010101100};
    vt[15] = '{1, 1, 0, 0, 9'b010101000};  // WRITE change after grant ignored
    vt[16] = '{1, 1, 0, 1, 9'b110111110};
    vt[17] = '{1, 1, 0, 1, 9'b111111110};
    vt[18] = '{0, 0, 1, 0, 9'b101111100};  // last owner CPU -> BUS wins
    vt[19] = '{1, 1, 0, 0, 9'b101010100};  // withdrawn requests do not abort
    vt[20] = '{1, 1, 0, 0, 9'b101010000};
    vt[21] = '{1, 1, 0, 1, 9'b111011110};

    drive(1, 1, 0, 1);
    sys_rst_n = 1'b0;
    model_reset();
    @(negedge sysclk);
    check("reset_outputs", obs, 9'b111111110);
    sys_rst_n = 1'b1;
    tick();
    check("idle_after_reset", obs, 9'b111111110);

    foreach (vt[i]) begin
      drive(vt[i].creq, vt[i].breq, vt[i].wr, vt[i].rdy);
      tick();
      check($sformatf("vec%0d", i), obs, vt[i].exp);
    end

    // Timeout: BUS holds, ready never arrives
    drive(1, 0, 0, 1);
    tick();
    BREQ_n = 1'b1;
    bact_lo = 0; tout_at_term = 0; tout_stray = 0; guard = 0;
    while (guard < 40) begin
      tick();
      if (!BACT_n) bact_lo++;
      if (!TERM_n && TOUT) tout_at_term++;
      if (TERM_n && TOUT) tout_stray++;
      guard++;
      if (BGNT_n) break;
    end
    check_int("timeout_bact_cycles", bact_lo, TMO + 1);
    check_int("timeout_tout_with_term", tout_at_term, 1);
    check_int("timeout_tout_stray", tout_stray, 0);

    // Ready coincident with the final count
    tick();
    drive(1, 0, 0, 1);
    tick();
    BREQ_n = 1'b1;
    tick();
    check("coinc_active_entry", {8'b0, BACT_n}, 9'b0);
    k = 1; guard = 0;
    while (TERM_n && guard < 40) begin
      RDY_n = (k == TMO) ? 1'b0 : 1'b1;
      tick();
      if (TERM_n) k++;
      guard++;
    end
    check_int("coinc_active_cycles", k, TMO);
    check("coinc_term_no_tout", {7'b0, TERM_n, TOUT}, 9'b0);

    // Asynchronous reset in the middle of a data phase
    tick();
    drive(0, 0, 0, 1);
    tick();
    tick();
    check("pre_reset_active", {7'b0, CACT_n & BACT_n, TERM_n}, 9'b1);
    #2 sys_rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_outputs", obs, 9'b111111110);
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    tick();
    check("post_reset_grant_cpu", {7'b0, CGNT_n, BGNT_n}, 9'b001);

    // CPU withdraws during the data phase; cycle still ends with a strobe
    drive(1, 1, 0, 1);
    guard = 0;
    while (!CGNT_n && guard < 40) begin tick(); guard++; end
    drive(0, 1, 1, 1);
    tick();
    CREQ_n = 1'b1;
    tick();
    tick();
    granted = 0; guard = 0;
    while (guard < 40) begin
      if (!TERM_n) granted++;
      if (CGNT_n) break;
      RDY_n = (guard == 3) ? 1'b0 : 1'b1;
      tick();
      guard++;
    end
    check_int("withdraw_term_pulses", granted, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 11) != 0));
      tick();
      exp_q.push_back(model_exp());
      check($sformatf("rand%0d", i), obs, exp_q.pop_front());
      if (!CGNT_n && !BGNT_n) check("grant_exclusive", {7'b0, CGNT_n, BGNT_n}, 9'b011);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
